// File: rtl/cam_capture_if.sv
// Memory-side write handshake between cam_capture and the SDRAM interface.
// The capture stage is the master: it presents address/data and the
// begin/end write strobes, and the memory interface answers with MEMIORDY.
interface cam_capture_if #(
    parameter int ADDR_W = 21
);
    logic [ADDR_W-1:0] CMEMADDR;
    logic [15:0]       CMEMDOUT;
    logic              CMEMnWE_asrt;
    logic              CMEMnWE_deas;
    logic              MEMIORDY;

    modport master (
        output CMEMADDR, CMEMDOUT, CMEMnWE_asrt, CMEMnWE_deas,
        input  MEMIORDY
    );

    modport slave (
        input  CMEMADDR, CMEMDOUT, CMEMnWE_asrt, CMEMnWE_deas,
        output MEMIORDY
    );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: samples an 8-bit parallel camera bus, packs byte pairs into
// RGB565 words, buffers them in a small FIFO and writes one frame per START
// into SDRAM through the cam_capture_if handshake.
// Optional macro CAM_CAPTURE_TESTPAT_EN adds a CAPT_TESTPAT input that
// replaces pixel data with {address[9:0], pixel-in-line[5:0]}.
// Each FIFO entry carries its own word address, so words dropped on overflow
// still consume an address and the image geometry stays intact.
module cam_capture #(
    parameter int HACT       = 640,
    parameter int VACT       = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 21
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CAM_PCLK,
    input  logic       CAM_VSYNC,
    input  logic       CAM_HREF,
    input  logic [7:0] CAM_D,
    input  logic       CAPT_EN,
    input  logic       START,
`ifdef CAM_CAPTURE_TESTPAT_EN
    input  logic       CAPT_TESTPAT,
`endif
    cam_capture_if.master mem,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVF
);
    localparam int TOTAL = HACT * VACT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_W + 16;

    typedef enum logic [2:0] {F_IDLE, F_ARM, F_CAPT, F_FLUSH, F_DONE} frame_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ASRT, W_WAIT, W_DEAS} wr_state_t;

    frame_state_t f_state_q, f_state_d;
    wr_state_t    w_state_q, w_state_d;

    // Synchroniser lanes: bit 2 = PCLK, bit 1 = VSYNC, bit 0 = HREF
    logic [2:0] s1_q, s2_q, hist_q;
    logic [7:0] d1_q, d2_q;

    logic       phase_q;
    logic [7:0] hi_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic [ADDR_W-1:0] push_addr_q;
    logic       done_q, ovf_q;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] cmem_addr_q;
    logic [15:0]       cmem_dout_q;

    logic frame_clear, push_en, push_ok, pop_en, fifo_empty, fifo_full;
    logic [15:0] push_data;

    wire pclk_rise = s2_q[2] & ~hist_q[2];
    wire vs_rise   = s2_q[1] & ~hist_q[1];
    wire vs_fall   = ~s2_q[1] & hist_q[1];
    wire href_sync = s2_q[0];
    wire href_fall = ~s2_q[0] & hist_q[0];
    wire last_pix  = (pix_cnt_q == CNT_W'(TOTAL - 1));

    // Two-flop synchronisers plus history flop; data delayed to line up with PCLK
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q   <= '0;
            s2_q   <= '0;
            hist_q <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
        end else begin
            s1_q   <= {CAM_PCLK, CAM_VSYNC, CAM_HREF};
            s2_q   <= s1_q;
            hist_q <= s2_q;
            d1_q   <= CAM_D;
            d2_q   <= d1_q;
        end
    end

    // Frame FSM state register
    always_ff @(posedge CLK) begin
        if (RST) f_state_q <= F_IDLE;
        else     f_state_q <= f_state_d;
    end

    // Frame FSM next state; dropping CAPT_EN aborts from any state
    always_comb begin
        f_state_d   = f_state_q;
        frame_clear = 1'b0;
        push_en     = 1'b0;
        if (!CAPT_EN) begin
            f_state_d = F_IDLE;
        end else begin
            case (f_state_q)
                F_IDLE:  if (START) begin
                             f_state_d   = F_ARM;
                             frame_clear = 1'b1;
                         end
                F_ARM:   if (vs_fall) f_state_d = F_CAPT;
                F_CAPT:  begin
                             push_en = pclk_rise & href_sync & phase_q;
                             if (vs_rise || (push_en && last_pix)) f_state_d = F_FLUSH;
                         end
                F_FLUSH: if (fifo_empty && (w_state_q == W_IDLE)) f_state_d = F_DONE;
                F_DONE:  f_state_d = F_IDLE;
                default: f_state_d = F_IDLE;
            endcase
        end
    end

    // Byte pairing, pixel/address counters and sticky status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q     <= 1'b0;
            hi_q        <= '0;
            pix_cnt_q   <= '0;
            push_addr_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (frame_clear) begin
                phase_q     <= 1'b0;
                pix_cnt_q   <= '0;
                push_addr_q <= '0;
                done_q      <= 1'b0;
                ovf_q       <= 1'b0;
            end else if (f_state_q == F_CAPT && CAPT_EN) begin
                if (href_fall) begin
                    phase_q <= 1'b0;            // dangling odd byte is discarded
                end else if (pclk_rise && href_sync) begin
                    phase_q <= ~phase_q;
                    if (!phase_q) hi_q <= d2_q;
                end
            end
            if (push_en) begin
                pix_cnt_q   <= pix_cnt_q + CNT_W'(1);
                push_addr_q <= push_addr_q + ADDR_W'(1);
            end
            if (push_en && fifo_full && !pop_en) ovf_q <= 1'b1;
            if (f_state_q == F_DONE) done_q <= 1'b1;
        end
    end

`ifdef CAM_CAPTURE_TESTPAT_EN
    logic [5:0] line_pix_q;

    // Word position within the current line, for the test pattern
    always_ff @(posedge CLK) begin
        if (RST || frame_clear || href_fall) line_pix_q <= '0;
        else if (push_en)                    line_pix_q <= line_pix_q + 6'd1;
    end

    assign push_data = CAPT_TESTPAT ? {push_addr_q[9:0], line_pix_q} : {hi_q, d2_q};
`else
    assign push_data = {hi_q, d2_q};
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_en     = (w_state_q == W_IDLE) && !fifo_empty && CAPT_EN;
    assign push_ok    = push_en && (!fifo_full || pop_en);

    // FIFO pointers; CAPT_EN low discards any buffered words
    always_ff @(posedge CLK) begin
        if (RST || !CAPT_EN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // FIFO storage: address travels with its data word
    always_ff @(posedge CLK) begin
        if (push_ok) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {push_addr_q, push_data};
    end

    // Writer FSM state register
    always_ff @(posedge CLK) begin
        if (RST) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    // Writer FSM next state: one outstanding write at a time
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (pop_en) w_state_d = W_ASRT;
            W_ASRT:  w_state_d = W_WAIT;
            W_WAIT:  if (mem.MEMIORDY) w_state_d = W_DEAS;
            W_DEAS:  w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Registered FIFO read straight into the write address/data outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmem_addr_q <= '0;
            cmem_dout_q <= '0;
        end else if (pop_en) begin
            {cmem_addr_q, cmem_dout_q} <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
        end
    end

    assign mem.CMEMADDR     = cmem_addr_q;
    assign mem.CMEMDOUT     = cmem_dout_q;
    assign mem.CMEMnWE_asrt = (w_state_q == W_ASRT);
    assign mem.CMEMnWE_deas = (w_state_q == W_DEAS);

    assign BUSY = (f_state_q == F_ARM) || (f_state_q == F_CAPT) || (f_state_q == F_FLUSH);
    assign DONE = done_q;
    assign OVF  = ovf_q;
endmodule

// File: tb/tb_cam_capture.sv
// Testbench for cam_capture with a tiny frame (HACT=4, VACT=2, FIFO_DEPTH=4).
// A background memory responder compares each write against a scoreboard
// queue filled when camera words are driven.
`timescale 1ns/1ps
module tb_cam_capture;
    localparam int HACT = 4, VACT = 2, FIFO_DEPTH = 4, ADDR_W = 21;

    logic clk = 1'b0;
    logic RST, CAM_PCLK, CAM_VSYNC, CAM_HREF, CAPT_EN, START;
    logic [7:0] CAM_D;
    logic BUSY, DONE, OVF;
`ifdef CAM_CAPTURE_TESTPAT_EN
    logic capt_testpat = 1'b0;
`endif

    cam_capture_if #(.ADDR_W(ADDR_W)) mem();

    cam_capture #(.HACT(HACT), .VACT(VACT), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(clk), .RST(RST), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF), .CAM_D(CAM_D), .CAPT_EN(CAPT_EN), .START(START),
`ifdef CAM_CAPTURE_TESTPAT_EN
        .CAPT_TESTPAT(capt_testpat),
`endif
        .mem(mem), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int n_writes = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [ADDR_W+15:0] exp_q[$];
    bit mem_hold = 1'b0;
    int mem_delay = 3;
    int pclk_half = 4;

    // Watchdog: never hang
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    // Memory responder and scoreboard checker
    initial begin : responder
        logic [ADDR_W-1:0] w_addr;
        logic [15:0] w_data;
        logic [ADDR_W+15:0] exp;
        int waited;
        mem.MEMIORDY = 1'b0;
        forever begin
            @(negedge clk);
            if (mem.CMEMnWE_asrt === 1'b1) begin
                w_addr = mem.CMEMADDR;
                w_data = mem.CMEMDOUT;
                n_writes++;
                last_addr = w_addr;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", w_addr, w_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({w_addr, w_data} !== exp) begin
                        tests_failed++;
                        $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 w_addr, w_data, exp[ADDR_W+15:16], exp[15:0]);
                    end
                end
                waited = 0;
                while (mem_hold || waited < mem_delay) begin
                    @(negedge clk);
                    waited++;
                    tests_run++;
                    if (mem.CMEMnWE_asrt !== 1'b0 || mem.CMEMnWE_deas !== 1'b0 ||
                        mem.CMEMADDR !== w_addr || mem.CMEMDOUT !== w_data) begin
                        tests_failed++;
                        $display("FAIL hold_stable: got asrt=%b deas=%b addr=%0d data=%h, expected 0 0 %0d %h",
                                 mem.CMEMnWE_asrt, mem.CMEMnWE_deas, mem.CMEMADDR, mem.CMEMDOUT, w_addr, w_data);
                    end
                end
                mem.MEMIORDY = 1'b1;
                @(negedge clk);
                mem.MEMIORDY = 1'b0;
                tests_run++;
                if (mem.CMEMnWE_deas !== 1'b1 || mem.CMEMADDR !== w_addr || mem.CMEMDOUT !== w_data) begin
                    tests_failed++;
                    $display("FAIL deas_pulse: got deas=%b addr=%0d data=%h, expected 1 %0d %h",
                             mem.CMEMnWE_deas, mem.CMEMADDR, mem.CMEMDOUT, w_addr, w_data);
                end
                @(negedge clk);
                tests_run++;
                if (mem.CMEMnWE_deas !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL deas_width: got deas=%b, expected 0", mem.CMEMnWE_deas);
                end
                $display("[TB] write addr=%0d data=%h", w_addr, w_data);
            end
        end
    end

    task automatic cam_byte(input logic [7:0] b);
        CAM_D = b;
        repeat (pclk_half) @(negedge clk);
        CAM_PCLK = 1'b1;
        repeat (pclk_half) @(negedge clk);
        CAM_PCLK = 1'b0;
    endtask

    // Drive one word; queue it as expected unless it is meant to vanish
    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input bit expect_it);
        if (expect_it) exp_q.push_back({exp_addr, hi, lo});
        exp_addr = exp_addr + ADDR_W'(1);
        cam_byte(hi);
        cam_byte(lo);
    endtask

    task automatic line_start();
        CAM_HREF = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic line_end();
        CAM_HREF = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // START pulse and the VSYNC pulse that opens the frame
    task automatic start_frame(output logic busy_seen);
        exp_addr = '0;
        n_writes = 0;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        busy_seen = BUSY;
        CAM_VSYNC = 1'b1;
        repeat (8) @(negedge clk);
        CAM_VSYNC = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", BUSY); end
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, expected 0", DONE); end
        tests_run++; if (OVF !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b, expected 0", OVF); end
        tests_run++; if (mem.CMEMnWE_asrt !== 1'b0) begin tests_failed++; $display("FAIL reset_asrt: got %b, expected 0", mem.CMEMnWE_asrt); end
        tests_run++; if (mem.CMEMnWE_deas !== 1'b0) begin tests_failed++; $display("FAIL reset_deas: got %b, expected 0", mem.CMEMnWE_deas); end
        tests_run++; if (mem.CMEMADDR !== '0) begin tests_failed++; $display("FAIL reset_addr: got %0d, expected 0", mem.CMEMADDR); end
        tests_run++; if (mem.CMEMDOUT !== 16'h0) begin tests_failed++; $display("FAIL reset_dout: got %h, expected 0000", mem.CMEMDOUT); end
        $display("[TB] reset checked");
    endtask

    // Full frame; also START during capture and a word beyond HACT*VACT
    task automatic test_small_frame();
        logic busy_seen;
        bit ok;
        mem_delay = 3;
        pclk_half = 4;
        start_frame(busy_seen);
        tests_run++; if (busy_seen !== 1'b1) begin tests_failed++; $display("FAIL small_busy: got %b, expected 1", busy_seen); end
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL small_done_early: got %b, expected 0", DONE); end
        for (int ln = 0; ln < VACT; ln++) begin
            line_start();
            for (int w = 0; w < HACT; w++)
                send_word(8'(ln*8 + w*2 + 1), 8'(ln*8 + w*2 + 2), 1'b1);
            if (ln == 0) begin
                START = 1'b1;
                @(negedge clk);
                START = 1'b0;
            end else begin
                send_word(8'hEE, 8'hFF, 1'b0);   // beyond frame size: never pushed
            end
            line_end();
        end
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL small_done: got DONE=%b, expected 1", DONE); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL small_busy_end: got %b, expected 0", BUSY); end
        tests_run++; if (n_writes !== HACT*VACT) begin tests_failed++; $display("FAIL small_writes: got %0d, expected %0d", n_writes, HACT*VACT); end
        tests_run++; if (last_addr !== ADDR_W'(HACT*VACT-1)) begin tests_failed++; $display("FAIL small_last_addr: got %0d, expected %0d", last_addr, HACT*VACT-1); end
        tests_run++; if (OVF !== 1'b0) begin tests_failed++; $display("FAIL small_ovf: got %b, expected 0", OVF); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL small_pending: got %0d left, expected 0", exp_q.size()); end
        $display("[TB] small frame: %0d writes", n_writes);
    endtask

    task automatic test_handshake();
        logic busy_seen;
        bit ok;
        for (int run = 0; run < 2; run++) begin
            mem_delay = (run == 0) ? 1 : 20;
            pclk_half = (run == 0) ? 4 : 12;
            start_frame(busy_seen);
            for (int ln = 0; ln < VACT; ln++) begin
                line_start();
                for (int w = 0; w < HACT; w++)
                    send_word(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1);
                line_end();
            end
            wait_done(ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL hs_done: delay=%0d got DONE=%b, expected 1", mem_delay, DONE); end
            tests_run++; if (n_writes !== HACT*VACT) begin tests_failed++; $display("FAIL hs_writes: delay=%0d got %0d, expected %0d", mem_delay, n_writes, HACT*VACT); end
            tests_run++; if (OVF !== 1'b0) begin tests_failed++; $display("FAIL hs_ovf: delay=%0d got %b, expected 0", mem_delay, OVF); end
            $display("[TB] handshake delay=%0d: %0d writes", mem_delay, n_writes);
        end
        pclk_half = 4;
    endtask

    // Writer stalled on word 0: words 1..4 fill the FIFO, word 5 is dropped
    task automatic test_overflow();
        logic busy_seen;
        bit ok;
        mem_delay = 1;
        mem_hold = 1'b1;
        start_frame(busy_seen);
        line_start();
        for (int w = 0; w < 4; w++) send_word(8'(8'h40 + w), 8'(8'h50 + w), 1'b1);
        line_end();
        line_start();
        send_word(8'h44, 8'h54, 1'b1);
        send_word(8'h45, 8'h55, 1'b0);
        tests_run++; if (OVF !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b, expected 1", OVF); end
        mem_hold = 1'b0;
        repeat (80) @(negedge clk);
        send_word(8'h46, 8'h56, 1'b1);
        send_word(8'h47, 8'h57, 1'b1);
        line_end();
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_done: got DONE=%b, expected 1", DONE); end
        tests_run++; if (OVF !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b, expected 1", OVF); end
        tests_run++; if (n_writes !== HACT*VACT-1) begin tests_failed++; $display("FAIL ovf_writes: got %0d, expected %0d", n_writes, HACT*VACT-1); end
        tests_run++; if (last_addr !== ADDR_W'(HACT*VACT-1)) begin tests_failed++; $display("FAIL ovf_last_addr: got %0d, expected %0d", last_addr, HACT*VACT-1); end
        $display("[TB] overflow: %0d writes, last addr %0d", n_writes, last_addr);
    endtask

    // 3-byte line yields one word; next line must restart at the high byte
    task automatic test_odd_byte();
        logic busy_seen;
        bit ok;
        mem_delay = 2;
        start_frame(busy_seen);
        tests_run++; if (OVF !== 1'b0) begin tests_failed++; $display("FAIL odd_ovf_cleared: got %b, expected 0", OVF); end
        line_start();
        send_word(8'hA1, 8'hA2, 1'b1);
        cam_byte(8'hA3);
        line_end();
        line_start();
        for (int w = 0; w < 4; w++) send_word(8'(8'hB0 + 2*w), 8'(8'hB1 + 2*w), 1'b1);
        line_end();
        line_start();
        for (int w = 0; w < 3; w++) send_word(8'(8'hC0 + 2*w), 8'(8'hC1 + 2*w), 1'b1);
        line_end();
        wait_done(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL odd_done: got DONE=%b, expected 1", DONE); end
        tests_run++; if (n_writes !== HACT*VACT) begin tests_failed++; $display("FAIL odd_writes: got %0d, expected %0d", n_writes, HACT*VACT); end
        $display("[TB] odd byte: %0d writes", n_writes);
    endtask

    task automatic test_abort();
        logic busy_seen;
        bit saw_deas;
        mem_delay = 2;
        mem_hold = 1'b1;
        start_frame(busy_seen);
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL abort_done_cleared: got %b, expected 0", DONE); end
        line_start();
        send_word(8'h11, 8'h22, 1'b1);
        send_word(8'h33, 8'h44, 1'b0);   // buffered, then flushed by the abort
        repeat (6) @(negedge clk);
        CAPT_EN = 1'b0;
        @(negedge clk);
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, expected 0", BUSY); end
        CAM_HREF = 1'b0;
        mem_hold = 1'b0;
        saw_deas = 1'b0;
        for (int i = 0; i < 200 && !saw_deas; i++) begin
            @(negedge clk);
            if (mem.CMEMnWE_deas === 1'b1) saw_deas = 1'b1;
        end
        tests_run++; if (!saw_deas) begin tests_failed++; $display("FAIL abort_deas: got no deas, expected deas"); end
        repeat (40) @(negedge clk);
        tests_run++; if (n_writes !== 1) begin tests_failed++; $display("FAIL abort_writes: got %0d, expected 1", n_writes); end
        tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL abort_done: got %b, expected 0", DONE); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL abort_pending: got %0d left, expected 0", exp_q.size()); end
        CAPT_EN = 1'b1;
        repeat (4) @(negedge clk);
        $display("[TB] abort: %0d writes", n_writes);
    endtask

    initial begin
        RST = 1'b1; CAM_PCLK = 1'b0; CAM_VSYNC = 1'b0; CAM_HREF = 1'b0;
        CAM_D = 8'h00; CAPT_EN = 1'b1; START = 1'b0;
        test_reset();
        test_small_frame();
        test_handshake();
        test_overflow();
        test_odd_byte();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
